// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared widths and hold-level constants for the pipeline control slice.
//   PC_CPU_W   - address/data width
//   PC_HOLD_W  - width of the hold-level bus
//   HOLD_*     - hold levels driven to the PC / IF / ID stages (higher = deeper stall)
//   sat_dec3   - 3-bit decrement that stops at zero
package pc_ctrl_pkg;

  localparam int PC_CPU_W  = 32;
  localparam int PC_HOLD_W = 3;

  localparam logic [PC_HOLD_W-1:0] HOLD_NONE = PC_HOLD_W'(0);
  localparam logic [PC_HOLD_W-1:0] HOLD_PC   = PC_HOLD_W'(1);
  localparam logic [PC_HOLD_W-1:0] HOLD_IF   = PC_HOLD_W'(2);
  localparam logic [PC_HOLD_W-1:0] HOLD_ID   = PC_HOLD_W'(3);

  function automatic logic [2:0] sat_dec3(input logic [2:0] val);
    return (val == 3'd0) ? 3'd0 : val - 3'd1;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds one buffered redirect target while the bus is stalled and
// merges it with any redirect request arriving in the current cycle.
//   clk, rst           - core clock, asynchronous active-low reset
//   trap_req_i/addr_i  - trap redirect request and target (highest priority)
//   ex_req_i/addr_i    - execute-stage jump request and target
//   store_i            - capture the merged request into the buffer
//   clear_i            - drop the buffered request (it is being issued)
//   sel_valid_o        - a redirect (buffered or new) is available this cycle
//   sel_addr_o         - target of that redirect after priority merge
module pc_redirect_buf #(
  parameter int CPU_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trap_req_i,
  input  logic [CPU_W-1:0] trap_addr_i,
  input  logic             ex_req_i,
  input  logic [CPU_W-1:0] ex_addr_i,
  input  logic             store_i,
  input  logic             clear_i,
  output logic             sel_valid_o,
  output logic [CPU_W-1:0] sel_addr_o
);

  logic             valid_q, valid_d;
  logic             trap_q, trap_d;
  logic [CPU_W-1:0] addr_q, addr_d;

  logic             req_any;
  logic [CPU_W-1:0] req_addr;
  logic             take_new;
  logic             sel_trap;

  always_comb begin
    req_any  = trap_req_i | ex_req_i;
    req_addr = trap_req_i ? trap_addr_i : ex_addr_i;
    // A new request replaces the buffer unless it is an execute jump trying
    // to displace a buffered trap target.
    take_new = req_any & (~valid_q | trap_req_i | ~trap_q);

    sel_valid_o = valid_q | req_any;
    sel_trap    = take_new ? trap_req_i : trap_q;
    sel_addr_o  = take_new ? req_addr   : addr_q;

    valid_d = valid_q;
    trap_d  = trap_q;
    addr_d  = addr_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (store_i) begin
      valid_d = 1'b1;
      trap_d  = sel_trap;
      addr_d  = sel_addr_o;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      trap_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      trap_q  <= trap_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter redirect sequencing and stall merging.
//   clk, rst          - core clock, asynchronous active-low reset
//   exJumpReqIn/Addr  - execute-stage branch/jump taken and target
//   trapReqIn/Addr    - trap/interrupt/mret redirect and target
//   busHoldIn         - bus not ready (stall, also defers redirects)
//   exHoldIn          - multi-cycle execute busy
//   trapHoldIn        - trap sequencer writing CSRs
//   jumpFlagOut       - one-cycle PC load strobe (registered)
//   jumpAddrOut       - PC load value, holds between strobes (registered)
//   holdFlagOut       - combinational hold level, max of all requesters
//   flushOut          - invalidate IF/ID (registered)
//   pendingOut        - a redirect is buffered waiting for the bus (registered)
//
// state | meaning
// RUN   | idle, no redirect in flight
// WAIT  | redirect buffered, bus still stalled
// ISSUE | cycle in which jumpFlagOut is high
// FLUSH | flush window counting down after an issue
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int CPU_W        = PC_CPU_W,
  parameter int HOLD_W       = PC_HOLD_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exJumpReqIn,
  input  logic [CPU_W-1:0]  exJumpAddrIn,
  input  logic              trapReqIn,
  input  logic [CPU_W-1:0]  trapAddrIn,
  input  logic              busHoldIn,
  input  logic              exHoldIn,
  input  logic              trapHoldIn,
  output logic              jumpFlagOut,
  output logic [CPU_W-1:0]  jumpAddrOut,
  output logic [HOLD_W-1:0] holdFlagOut,
  output logic              flushOut,
  output logic              pendingOut
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic [1:0]       state_q, state_d;
  logic             jump_flag_q, jump_flag_d;
  logic [CPU_W-1:0] jump_addr_q, jump_addr_d;
  logic             flush_q, flush_d;
  logic             pending_q, pending_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;

  logic [PC_HOLD_W-1:0] hold_lvl;
  logic                 sel_valid;
  logic [CPU_W-1:0]     sel_addr;
  logic                 issue;
  logic                 park;
  logic [2:0]           cnt_dec;

  always_comb begin
    hold_lvl = HOLD_NONE;
    if (trapHoldIn)              hold_lvl = HOLD_IF;
    if (busHoldIn || exHoldIn)   hold_lvl = HOLD_ID;
  end

  assign holdFlagOut = HOLD_W'(hold_lvl);

  pc_redirect_buf #(.CPU_W(CPU_W)) u_redirect_buf (
    .clk         (clk),
    .rst         (rst),
    .trap_req_i  (trapReqIn),
    .trap_addr_i (trapAddrIn),
    .ex_req_i    (exJumpReqIn),
    .ex_addr_i   (exJumpAddrIn),
    .store_i     (park),
    .clear_i     (issue),
    .sel_valid_o (sel_valid),
    .sel_addr_o  (sel_addr)
  );

  // Redirects are accepted in every state; the only thing that defers one is
  // the bus stall, in which case the merged target is parked in the buffer.
  assign issue = sel_valid & ~busHoldIn;
  assign park  = sel_valid &  busHoldIn;

  always_comb begin
    cnt_dec     = sat_dec3(flush_cnt_q);
    state_d     = state_q;
    jump_flag_d = 1'b0;
    jump_addr_d = jump_addr_q;
    // The counter keeps draining in WAIT so an earlier flush window still
    // ends on time if a new redirect gets parked behind the bus.
    flush_cnt_d = cnt_dec;

    if (issue) begin
      state_d     = ST_ISSUE;
      jump_flag_d = 1'b1;
      jump_addr_d = sel_addr;
      flush_cnt_d = FLUSH_LOAD;
    end else if (park) begin
      state_d = ST_WAIT;
    end else begin
      case (state_q)
        ST_ISSUE: state_d = ST_FLUSH;
        ST_FLUSH: state_d = (cnt_dec == 3'd0) ? ST_RUN : ST_FLUSH;
        default:  state_d = ST_RUN;
      endcase
    end

    // Counter holds the number of flush cycles still to show, including the
    // one being registered now.
    flush_d   = (flush_cnt_d != 3'd0);
    pending_d = park;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      jump_flag_q <= 1'b0;
      jump_addr_q <= '0;
      flush_q     <= 1'b0;
      pending_q   <= 1'b0;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      jump_flag_q <= jump_flag_d;
      jump_addr_q <= jump_addr_d;
      flush_q     <= flush_d;
      pending_q   <= pending_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign jumpFlagOut = jump_flag_q;
  assign jumpAddrOut = jump_addr_q;
  assign flushOut    = flush_q;
  assign pendingOut  = pending_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the redirect/flush/hold behaviour.
module tb_pc_ctrl;

  localparam int CPU_W  = 32;
  localparam int HOLD_W = 3;
  localparam int FC     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              exJumpReqIn = 1'b0;
  logic [CPU_W-1:0]  exJumpAddrIn = '0;
  logic              trapReqIn = 1'b0;
  logic [CPU_W-1:0]  trapAddrIn = '0;
  logic              busHoldIn = 1'b0;
  logic              exHoldIn = 1'b0;
  logic              trapHoldIn = 1'b0;
  logic              jumpFlagOut;
  logic [CPU_W-1:0]  jumpAddrOut;
  logic [HOLD_W-1:0] holdFlagOut;
  logic              flushOut;
  logic              pendingOut;

  always #5 clk = ~clk;

  pc_ctrl #(.CPU_W(CPU_W), .HOLD_W(HOLD_W), .FLUSH_CYCLES(FC)) dut (
    .clk          (clk),
    .rst          (rst),
    .exJumpReqIn  (exJumpReqIn),
    .exJumpAddrIn (exJumpAddrIn),
    .trapReqIn    (trapReqIn),
    .trapAddrIn   (trapAddrIn),
    .busHoldIn    (busHoldIn),
    .exHoldIn     (exHoldIn),
    .trapHoldIn   (trapHoldIn),
    .jumpFlagOut  (jumpFlagOut),
    .jumpAddrOut  (jumpAddrOut),
    .holdFlagOut  (holdFlagOut),
    .flushOut     (flushOut),
    .pendingOut   (pendingOut)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: at most one buffered redirect, an issue log
  // (cycle of last issue) and the address last sent to the PC.
  int               cyc = 0;
  int               last_issue = -1000;
  bit               m_jump = 1'b0;
  logic [CPU_W-1:0] m_addr = '0;
  bit               p_valid = 1'b0;
  bit               p_trap = 1'b0;
  logic [CPU_W-1:0] p_addr = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc = 0; last_issue = -1000; m_jump = 0; m_addr = '0;
      p_valid = 0; p_trap = 0; p_addr = '0;
    end else begin
      bit have;
      bit t;
      logic [CPU_W-1:0] a;
      cyc++;
      have = p_valid; t = p_trap; a = p_addr;
      if (trapReqIn) begin
        have = 1; t = 1; a = trapAddrIn;
      end else if (exJumpReqIn && !(p_valid && p_trap)) begin
        have = 1; t = 0; a = exJumpAddrIn;
      end
      m_jump = 0;
      if (have && !busHoldIn) begin
        m_jump = 1; m_addr = a; last_issue = cyc; p_valid = 0;
      end else if (have) begin
        p_valid = 1; p_trap = t; p_addr = a;
      end
    end
  end

  function automatic int exp_hold();
    int lvl = 0;
    if (trapHoldIn && lvl < 2) lvl = 2;
    if (exHoldIn   && lvl < 3) lvl = 3;
    if (busHoldIn  && lvl < 3) lvl = 3;
    return lvl;
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      check("jumpFlag",  64'(jumpFlagOut), 64'(m_jump));
      check("jumpAddr",  64'(jumpAddrOut), 64'(m_addr));
      check("flush",     64'(flushOut),
            64'((cyc - last_issue) >= 0 && (cyc - last_issue) < FC));
      check("pending",   64'(pendingOut),  64'(p_valid));
      check("holdLevel", 64'(holdFlagOut), 64'(exp_hold()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exJumpReqIn = 0; trapReqIn = 0; busHoldIn = 0; exHoldIn = 0; trapHoldIn = 0;
  endtask

  initial begin
    #1 rst = 0;
    checking = 1;
    #1;
    check("rst_jump",  64'(jumpFlagOut), 64'd0);
    check("rst_addr",  64'(jumpAddrOut), 64'd0);
    check("rst_flush", 64'(flushOut),    64'd0);
    repeat (3) step();
    rst = 1;

    // single execute redirect, bus free
    exJumpReqIn = 1; exJumpAddrIn = 32'h100;
    step();
    check("t1_jump", 64'(jumpFlagOut), 64'd1);
    check("t1_addr", 64'(jumpAddrOut), 64'h100);
    check("t1_flush0", 64'(flushOut), 64'd1);
    exJumpReqIn = 0;
    step();
    check("t1_jump_pulse", 64'(jumpFlagOut), 64'd0);
    check("t1_flush1", 64'(flushOut), 64'd1);
    step();
    check("t1_flush_end", 64'(flushOut), 64'd0);

    // simultaneous trap and execute
    trapReqIn = 1; trapAddrIn = 32'h80; exJumpReqIn = 1; exJumpAddrIn = 32'h200;
    step();
    check("t2_jump", 64'(jumpFlagOut), 64'd1);
    check("t2_addr", 64'(jumpAddrOut), 64'h80);
    idle_inputs();
    step();
    check("t2_single", 64'(jumpFlagOut), 64'd0);
    check("t2_addr_hold", 64'(jumpAddrOut), 64'h80);
    repeat (2) step();

    // redirects buffered behind a 5-cycle bus stall, trap overrides execute
    busHoldIn = 1; exJumpReqIn = 1; exJumpAddrIn = 32'h300;
    #1 check("t3_hold", 64'(holdFlagOut), 64'd3);
    step();
    check("t3_pending", 64'(pendingOut), 64'd1);
    check("t3_nojump", 64'(jumpFlagOut), 64'd0);
    exJumpReqIn = 0;
    step();
    trapReqIn = 1; trapAddrIn = 32'h80;
    step();
    trapReqIn = 0;
    step();
    step();
    check("t3_pending_late", 64'(pendingOut), 64'd1);
    busHoldIn = 0;
    step();
    check("t3_jump", 64'(jumpFlagOut), 64'd1);
    check("t3_addr", 64'(jumpAddrOut), 64'h80);
    check("t3_pending_clr", 64'(pendingOut), 64'd0);
    step();
    check("t3_single", 64'(jumpFlagOut), 64'd0);
    repeat (2) step();

    // hold-level merging, combinational
    trapHoldIn = 1; exHoldIn = 1;
    #1 check("t4_both", 64'(holdFlagOut), 64'd3);
    exHoldIn = 0;
    #1 check("t4_trap", 64'(holdFlagOut), 64'd2);
    trapHoldIn = 0;
    #1 check("t4_none", 64'(holdFlagOut), 64'd0);
    step();

    // second redirect during the flush window
    exJumpReqIn = 1; exJumpAddrIn = 32'h100;
    step();
    exJumpReqIn = 0;
    step();
    exJumpReqIn = 1; exJumpAddrIn = 32'h400;
    step();
    check("t5_jump", 64'(jumpFlagOut), 64'd1);
    check("t5_addr", 64'(jumpAddrOut), 64'h400);
    exJumpReqIn = 0;
    step();
    check("t5_flush_ext", 64'(flushOut), 64'd1);
    step();
    check("t5_flush_end", 64'(flushOut), 64'd0);

    // reset while a redirect is buffered
    busHoldIn = 1; exJumpReqIn = 1; exJumpAddrIn = 32'h300;
    step();
    exJumpReqIn = 0;
    step();
    check("t6_pending", 64'(pendingOut), 64'd1);
    rst = 0;
    #1;
    check("t6_rst_jump", 64'(jumpFlagOut), 64'd0);
    check("t6_rst_addr", 64'(jumpAddrOut), 64'd0);
    check("t6_rst_flush", 64'(flushOut), 64'd0);
    check("t6_rst_pend", 64'(pendingOut), 64'd0);
    step();
    rst = 1; busHoldIn = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_jump", 64'(jumpFlagOut), 64'd0);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step();
      if ($urandom_range(0, 249) == 0) begin
        rst = 0; #1; rst = 1;
      end
      busHoldIn    = ($urandom_range(0, 99) < 35);
      exJumpReqIn  = ($urandom_range(0, 99) < 20);
      trapReqIn    = ($urandom_range(0, 99) < 10);
      exHoldIn     = ($urandom_range(0, 3) == 0);
      trapHoldIn   = ($urandom_range(0, 3) == 0);
      exJumpAddrIn = $urandom() & 32'hFFFF_FFFC;
      trapAddrIn   = $urandom() & 32'hFFFF_FFFC;
    end
    idle_inputs();
    repeat (4) step();
    checking = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Pipeline control unit that sequences the program-counter register and the fetch/decode stages. It arbitrates PC redirect requests from the execute stage and the trap unit, and merges stall requests from the bus, the multi-cycle execute unit and the trap sequencer into one hold level. It also buffers a redirect that arrives while the bus is stalled and times the post-redirect flush window. It sits between the execute/CSR logic and the PC register, IF/ID pipeline register and fetch unit.

## Interface
- CPU_W, 32, address/data width
- HOLD_W, 3, hold-level bus width
- FLUSH_CYCLES, 2, cycles flushOut stays high after a redirect is issued (1..7)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- exJumpReqIn  in  1  execute-stage branch/jump taken
- exJumpAddrIn  in  CPU_W  execute-stage target
- trapReqIn  in  1  trap/interrupt entry or mret redirect
- trapAddrIn  in  CPU_W  trap target
- busHoldIn  in  1  instruction/data bus not ready
- exHoldIn  in  1  multi-cycle execute busy (div)
- trapHoldIn  in  1  trap sequencer writing CSRs
- jumpFlagOut  out  1  PC load strobe to PC register
- jumpAddrOut  out  CPU_W  PC load value
- holdFlagOut  out  HOLD_W  hold level to PC/IF/ID
- flushOut  out  1  invalidate IF/ID contents
- pendingOut  out  1  a redirect is buffered (debug/verification visibility)

## Operation
- Hold levels are shared constants: HOLD_NONE=0, HOLD_PC=1, HOLD_IF=2, HOLD_ID=3.
- Source levels:
  - busHoldIn requests HOLD_ID.
  - exHoldIn requests HOLD_ID.
  - trapHoldIn requests HOLD_IF.
- holdFlagOut is combinational: the maximum level requested. It is HOLD_NONE when no request is active.
- Redirect priority: trap over execute. When both arrive in one cycle, the trap target wins and the execute request is dropped.
- State machine:
  - RUN → ISSUE: on a redirect request with busHoldIn low.
  - RUN → WAIT: on a redirect request with busHoldIn high. The target is latched into the pending register.
  - WAIT → ISSUE: on the first cycle busHoldIn is low.
  - ISSUE → FLUSH: always, after one cycle.
  - FLUSH → RUN: when the flush counter reaches 0.
- Pending register, in WAIT:
  - A new trap request overwrites a pending execute target.
  - An execute request never overwrites a pending trap target.
  - A later request of equal class overwrites the pending target.
- A redirect request in FLUSH is accepted exactly as in RUN. The counter restarts on its ISSUE.
- Redirect requests in ISSUE are accepted and go to ISSUE or WAIT next cycle; the flush counter reloads.
- jumpFlagOut, jumpAddrOut, flushOut and pendingOut are registered.

## Timing
- Reset (rst low, asynchronous):
  - state=RUN
  - jumpFlagOut=0
  - jumpAddrOut=0
  - flushOut=0
  - pendingOut=0
  - flush counter=0
  - pending register cleared
- Reset mid-WAIT or mid-FLUSH discards the buffered target; no redirect is issued after release.
- Redirect latency: a request in cycle N with bus free gives jumpFlagOut=1 and the target on jumpAddrOut in cycle N+1. jumpFlagOut is high for exactly one cycle.
- flushOut is high from cycle N+1 through N+FLUSH_CYCLES inclusive.
- WAIT: pendingOut=1 from the cycle after latching until jumpFlagOut is asserted. jumpFlagOut rises the cycle after busHoldIn falls.
- jumpAddrOut holds its last value when jumpFlagOut=0.
- Flush counter: 3-bit, loaded with FLUSH_CYCLES in ISSUE, decrements in FLUSH, never wraps below 0.

## Structure
- Hold-level constants, HOLD_W and CPU_W belong in the shared defines header alongside the existing bus-width macros.
- The state encoding is local.
- One natural sub-module: pc_redirect_buf, holding the pending target, its class bit, and the overwrite-priority logic.

## Test plan
- Reset then exJumpReqIn=1 with target 0x0000_0100 for 1 cycle → next cycle jumpFlagOut=1, jumpAddrOut=0x100; flushOut high for 2 cycles; state back to RUN.
- trapReqIn (0x0000_0080) and exJumpReqIn (0x200) in the same cycle → only 0x80 issued, single jumpFlagOut pulse.
- busHoldIn high for 5 cycles, exJumpReqIn (0x300) in cycle 1, trapReqIn (0x80) in cycle 3 → holdFlagOut=HOLD_ID throughout; pendingOut=1; one jump to 0x80 the cycle after busHoldIn falls.
- trapHoldIn and exHoldIn both high → holdFlagOut=3; trapHoldIn alone → 2; none → 0, same cycle.
- Second exJumpReqIn (0x400) during FLUSH → jump to 0x400 next cycle; flushOut extends to 2 cycles from the new issue.
- rst pulsed low while in WAIT with 0x300 pending → all outputs 0 immediately; no jump after release.
